// File: rtl/mem_port_if.sv
// Bundle of the datapath request side and the word-wide memory bus side of
// the load/store unit. The master modport is the load/store unit's view;
// the slave modport is the view of whatever surrounds it (datapath + memory).
interface mem_port_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_size;
  logic [31:0]   req_wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic          fault;
  logic          bus_valid;
  logic          bus_ready;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_rvalid;
  logic [31:0]   bus_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    input  bus_ready, bus_rvalid, bus_rdata,
    output rdata, ack, fault,
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    output bus_ready, bus_rvalid, bus_rdata,
    input  rdata, ack, fault,
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_port.sv
// Load/store unit: takes one datapath memory request, runs a single
// valid/ready bus transaction with byte enables, and returns extended load
// data with a one-cycle ack. Misaligned or illegal-size requests are
// answered locally with fault and never touch the bus.
module mem_port #(
  parameter int AW = 32
) (
  input logic        clk,
  input logic        rst_n,
  mem_port_if.master mp
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          fault_q, fault_d;
  logic          bus_valid_q, bus_valid_d;
  logic          bus_we_q, bus_we_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;

  logic          size_ok;
  logic          misaligned;
  logic [3:0]    req_be;
  logic [31:0]   req_lanes;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  // Decode the incoming request: legality, byte enables and lane-replicated store data.
  always_comb begin
    size_ok    = 1'b0;
    misaligned = 1'b0;
    req_be     = 4'hF;
    req_lanes  = mp.req_wdata;
    case (mp.req_size)
      3'd0, 3'd4: begin
        size_ok   = 1'b1;
        req_be    = 4'b0001 << mp.req_addr[1:0];
        req_lanes = {4{mp.req_wdata[7:0]}};
      end
      3'd1, 3'd5: begin
        size_ok    = 1'b1;
        misaligned = mp.req_addr[0];
        req_be     = 4'b0011 << mp.req_addr[1:0];
        req_lanes  = {2{mp.req_wdata[15:0]}};
      end
      3'd2: begin
        size_ok    = 1'b1;
        misaligned = (mp.req_addr[1:0] != 2'b00);
      end
      default: size_ok = 1'b0;
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    shifted = mp.bus_rdata >> {off_q, 3'b000};
    case (size_q)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd4:    load_data = {24'h000000, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd5:    load_data = {16'h0000, shifted[15:0]};
      default: load_data = mp.bus_rdata;
    endcase
  end

  // Next-state and registered-output logic; everything holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    ack_d       = 1'b0;
    bus_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mp.req_valid) begin
          if (!size_ok || misaligned) begin
            state_d = DONE;
            ack_d   = 1'b1;
            fault_d = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d     = REQ;
            bus_valid_d = 1'b1;
            off_d       = mp.req_addr[1:0];
            size_d      = mp.req_size;
            bus_we_d    = mp.req_write;
            bus_addr_d  = {mp.req_addr[AW-1:2], 2'b00};
            bus_be_d    = req_be;
            bus_wdata_d = req_lanes;
          end
        end
      end
      REQ: begin
        bus_valid_d = 1'b1;
        if (mp.bus_ready) begin
          bus_valid_d = 1'b0;
          if (bus_we_q) begin
            state_d = DONE;
            ack_d   = 1'b1;
            fault_d = 1'b0;
          end else if (mp.bus_rvalid) begin
            state_d = DONE;
            ack_d   = 1'b1;
            fault_d = 1'b0;
            rdata_d = load_data;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (mp.bus_rvalid) begin
          state_d = DONE;
          ack_d   = 1'b1;
          fault_d = 1'b0;
          rdata_d = load_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously so a reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      size_q      <= 3'd0;
      rdata_q     <= 32'h0;
      ack_q       <= 1'b0;
      fault_q     <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      fault_q     <= fault_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign mp.rdata     = rdata_q;
  assign mp.ack       = ack_q;
  assign mp.fault     = fault_q;
  assign mp.bus_valid = bus_valid_q;
  assign mp.bus_we    = bus_we_q;
  assign mp.bus_addr  = bus_addr_q;
  assign mp.bus_be    = bus_be_q;
  assign mp.bus_wdata = bus_wdata_q;

endmodule

// File: doc/mem_port.md
# mem_port

Load/store unit between the datapath's memory request outputs and the external word-wide memory bus. Serves both instruction fetches and data accesses. It captures one request, drives a valid/ready bus transaction with byte enables, and waits for the read response. It then returns aligned, sign- or zero-extended load data with a one-cycle completion pulse. Misaligned and illegal-size accesses are rejected locally and never reach the bus.

## Interface
- `AW`, 32, byte address width.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: access request; held high by the datapath until `ack`.
- `req_write` in 1: 1 = store, 0 = load/fetch.
- `req_addr` in AW: byte address (datapath `mem_addr`).
- `req_size` in 3: funct3 encoding (datapath `mem_size`).
  - 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
  - 3, 6, 7 are illegal.
- `req_wdata` in 32: store data, right-justified.
- `rdata` out 32: registered load result (datapath `memread_data`).
- `ack` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `ack`; 1 = misaligned or illegal size.
- `bus_valid` out 1: bus request.
- `bus_ready` in 1: bus accepts the request.
- `bus_we` out 1: write enable.
- `bus_addr` out AW: word-aligned address, bits [1:0] = 0.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - `req_valid` = 1 with a legal, aligned access: latch `req_write`, `req_addr[1:0]`, `req_size`. Register `bus_addr`, `bus_be`, `bus_we`, `bus_wdata`. Go to REQ.
  - Misaligned or illegal access: go to DONE with `fault` = 1 and `rdata` = 0. No bus activity.
- REQ: `bus_valid` = 1; all bus outputs are stable until `bus_ready` = 1.
  - `bus_ready` and write: go to DONE.
  - `bus_ready` and read, `bus_rvalid` = 1 in the same cycle: capture the data, go to DONE.
  - `bus_ready` and read, no `bus_rvalid`: go to RESP.
- RESP: `bus_valid` = 0. Wait for `bus_rvalid`, capture the data, go to DONE.
- DONE: `ack` = 1 for exactly one cycle, then go to IDLE.
  - `rdata` and `fault` hold until the next DONE.
  - `req_valid` still high in this cycle is not treated as a new request. Only IDLE samples `req_valid`.
- Alignment rules:
  - H/HU is misaligned when `addr[0]` = 1.
  - W is misaligned when `addr[1:0]` ≠ 0.
  - B/BU is never misaligned.
- Byte enables, with o = `addr[1:0]`:
  - B/BU: 4'b0001 << o.
  - H/HU: 4'b0011 << o.
  - W: 4'b1111.
- Store data:
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: `wdata` unchanged.
- Load extraction:
  - Take byte/half from lane o of `bus_rdata`.
  - B/H: sign-extend. BU/HU: zero-extend. W: pass through.
- Bus signals:
  - `bus_rvalid` outside REQ/RESP is ignored.
  - `bus_ready` outside REQ is ignored.
- Writes never wait for `bus_rvalid`. A write's `rdata` is left unchanged.

## Timing
- Reset values, applied asynchronously:
  - State IDLE.
  - `bus_valid`, `ack`, `fault`, `bus_we` = 0.
  - `rdata`, `bus_addr`, `bus_wdata` = 0; `bus_be` = 0.
- All outputs are registered.
- Cycle 0 is IDLE with `req_valid` high.
  - `bus_valid` rises in cycle 1.
  - Zero-wait read or write (`bus_ready` in cycle 1, plus `bus_rvalid` for a read): `ack` in cycle 2.
- Each cycle of `bus_ready` low adds one cycle. Each cycle of response wait in RESP adds one cycle.
- Fault path: `ack` with `fault` = 1 in cycle 1.
- Back-to-back: the earliest next request is sampled the cycle after `ack`.
- Reset mid-transaction drops the access: no `ack`. A late `bus_rvalid` after reset is ignored in IDLE.

## Test plan
- Zero-wait LW:
  - Stimulus: addr 0x100; bus returns 0xDEADBEEF with `ready` and `rvalid` in cycle 1.
  - Required: `bus_addr` = 0x100, `be` = 4'hF; `ack` in cycle 2, `rdata` = 0xDEADBEEF, `fault` = 0.
- LB/LBU at addr 0x103, bus word 0x80FF_0000:
  - LB: `be` = 4'b1000, `rdata` = 0xFFFFFF80.
  - LBU: `rdata` = 0x00000080.
- SH at addr 0x202, wdata 0x1234ABCD, `bus_ready` delayed 3 cycles:
  - `bus_valid` held 4 cycles with `be` = 4'b1100, `wdata` = 0xABCDABCD, `we` = 1.
  - `ack` one cycle after `ready`.
- Misaligned accesses:
  - LW at 0x101: `ack` in cycle 1 with `fault` = 1, `rdata` = 0; `bus_valid` never rises.
  - SH at 0x203: same response.
- Read with `rvalid` 2 cycles after `ready`: RESP is entered and `bus_valid` drops. `ack` comes the cycle after `rvalid`. `req_valid` held through DONE does not start a second access.
- `rst_n` pulsed low while in RESP: all outputs 0 immediately. A later `bus_rvalid` produces no `ack`. The next LW completes normally.
